spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- FPGA-side SPI master that generates sck and shifts a 32-bit word out on sdo, MSB first, while capturing 32 bits from sdi.
- Counterpart to the existing spi_slave receiver. Used to stream filtered samples and peak counts back to the microcontroller, and for on-board loopback against spi_slave.
- Mode 0: sck idles low; the peer samples on the sck rising edge; data changes on the sck falling edge.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period; legal range is 1 or greater; sck frequency = clk / (2*CLK_DIV).
- FRAME_BITS, 32, bits per frame; legal range is 2 or greater.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; the block resets when reset==0 at a clk rising edge.
- start  input  1  frame request; sampled only when busy==0.
- din  input  FRAME_BITS  word to transmit; captured on the accepting edge.
- sdi  input  1  serial data from the slave.
- sck  output  1  serial clock to the slave.
- sdo  output  1  serial data to the slave.
- dout  output  FRAME_BITS  word received in the last completed frame.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered.
- Reset values: sck=0, sdo=0, busy=0, done=0, dout=0. Internal state is IDLE, the divider counter is 0, and the bit counter is 0.
- States: IDLE, HIGH_PHASE, LOW_PHASE.
- IDLE:
  - sck=0; sdo holds its last value.
  - If start==1 at edge E0: capture din into tx_shift, set sdo=din[MSB], busy=1, divider=0, bit counter=0, next state LOW_PHASE. The first phase is a lead-in low phase.
- Divider:
  - Increments every cycle while busy.
  - When divider==CLK_DIV-1, reset it to 0 and toggle the phase.
- LOW_PHASE to HIGH_PHASE, at edges E0+CLK_DIV, E0+3*CLK_DIV, and so on:
  - sck<=1.
  - rx_shift <= {rx_shift[FRAME_BITS-2:0], sdi}, sampling sdi at that same clk edge.
  - Bit counter increments.
- HIGH_PHASE to LOW_PHASE:
  - sck<=0.
  - If bit counter < FRAME_BITS: tx_shift shifts left and sdo <= next bit.
  - If bit counter == FRAME_BITS: the frame ends at this edge, E0+2*FRAME_BITS*CLK_DIV. Set busy<=0, done<=1, dout<=rx_shift, and go to IDLE. sdo holds the last bit.
- done is high for exactly one cycle. Otherwise done=0.
- Latency: start accepted at E0 leads to done at E0+2*FRAME_BITS*CLK_DIV. With the defaults this is 256 cycles.
- start while busy is ignored. It is not queued.
- start in the cycle where done==1: accepted, because busy==0 in that cycle. Back-to-back frames have a 1-cycle idle gap with sck low.
- din changes after acceptance have no effect on the frame in progress.
- dout changes only on frame completion and is stable between frames.
- Reset mid-frame: the frame is aborted immediately at that edge. All outputs take reset values and no done pulse is issued.
- CLK_DIV=1: sck toggles every clk cycle and the above rules hold unchanged.

Optional Feature:
- Macro: SPI_MASTER_CS_EN.
- Defined:
  - Adds output port cs_n (1 bit), reset value 1.
  - cs_n<=0 at the accepting edge E0, so it falls CLK_DIV cycles before the first sck rise.
  - At the frame-end edge, sck falls and the state enters a CS_HOLD state for CLK_DIV cycles. At the end of that hold, cs_n<=1, done<=1 and busy<=0, so done latency becomes E0+(2*FRAME_BITS+1)*CLK_DIV.
  - Mid-frame reset forces cs_n=1.
- Undefined: no cs_n port, no CS_HOLD state, and timing as in Behaviour.

Test Plan:
- Basic frame, defaults: din=32'hA5A5_00FF with start pulsed at E0; a bench slave model captures sdo on sck rising edges and drives 32'h1234_5678 on sdi, changing on falling edges.
  - Required: the model receives 32'hA5A5_00FF.
  - Required: dout=32'h1234_5678; done pulses only at E0+256; busy is high from E0+1 through E0+256.
  - Required: exactly 32 sck rising edges.
- Loopback, CLK_DIV=1: sdi tied to sdo through a 1-cycle-delay-free connection, din=32'hDEAD_BEEF -> dout=32'hDEAD_BEEF, done at E0+64, and sck period of 2 clk cycles.
- Start while busy: a second start with din=32'h0 at E0+50 -> ignored; the model still receives 32'hA5A5_00FF and only one done occurs.
- Back-to-back: start held high continuously with din=32'h0000_0001 and then 32'h8000_0000 -> two frames are received in order; a single idle cycle separates them with sck=0; done pulses twice, 257 cycles apart.
- Reset mid-frame: reset=0 for one cycle at E0+100 -> at the next edge sck=0, sdo=0, busy=0, dout=0 and no done; a new start after reset completes normally.
- With SPI_MASTER_CS_EN, defaults -> cs_n falls at E0, the first sck rise is at E0+4, cs_n rises together with done at E0+260, and cs_n stays 1 throughout reset.

Source files
------------

// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI master shifting FRAME_BITS words out MSB first while capturing sdi.
// Define SPI_MASTER_CS_EN to add an active-low cs_n with a trailing CS_HOLD phase.
module spi_master_tx #(
   parameter int CLK_DIV    = 4,
   parameter int FRAME_BITS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] din,
   input  logic                  sdi,
   output logic                  sck,
   output logic                  sdo,
   output logic [FRAME_BITS-1:0] dout,
   output logic                  busy,
   output logic                  done
`ifdef SPI_MASTER_CS_EN
   ,
   output logic                  cs_n
`endif
);
   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam int BW = $clog2(FRAME_BITS + 1);
   typedef enum logic [1:0] {
      IDLE,
      HIGH_PHASE,
      LOW_PHASE
`ifdef SPI_MASTER_CS_EN
      ,
      CS_HOLD
`endif
   } state_t;
   state_t                state;
   logic [DW-1:0]         div;
   logic [BW-1:0]         bits;
   logic [FRAME_BITS-2:0] tx_shift;
   logic [FRAME_BITS-1:0] rx_shift;
   logic                  tick;
   always_comb tick = div == DW'(CLK_DIV - 1);
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         div      <= '0;
         bits     <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         sck      <= 1'b0;
         sdo      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dout     <= '0;
`ifdef SPI_MASTER_CS_EN
         cs_n     <= 1'b1;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            sck <= 1'b0;
            div <= '0;
            if (start) begin
               tx_shift <= din[FRAME_BITS-2:0];
               sdo      <= din[FRAME_BITS-1];
               busy     <= 1'b1;
               bits     <= '0;
               state    <= LOW_PHASE;
`ifdef SPI_MASTER_CS_EN
               cs_n     <= 1'b0;
`endif
            end
         end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
               case (state)
                  LOW_PHASE: begin
                     sck      <= 1'b1;
                     rx_shift <= {rx_shift[FRAME_BITS-2:0], sdi};
                     bits     <= bits + 1'b1;
                     state    <= HIGH_PHASE;
                  end
                  HIGH_PHASE: begin
                     sck <= 1'b0;
                     if (bits == BW'(FRAME_BITS)) begin
`ifdef SPI_MASTER_CS_EN
                        state <= CS_HOLD;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        dout  <= rx_shift;
                        state <= IDLE;
`endif
                     end else begin
                        // sdo takes the bit just below the one on the wire, then the register advances
                        sdo      <= tx_shift[FRAME_BITS-2];
                        tx_shift <= tx_shift << 1;
                        state    <= LOW_PHASE;
                     end
                  end
`ifdef SPI_MASTER_CS_EN
                  CS_HOLD: begin
                     cs_n  <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     dout  <= rx_shift;
                     state <= IDLE;
                  end
`endif
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: randomized frames on a CLK_DIV=4 master driven by a slave model, plus a CLK_DIV=1 loopback master.
module tb_spi_master_tx;
   localparam int FB = 32;
   localparam int CD = 4;
`ifdef SPI_MASTER_CS_EN
   localparam int LA    = (2*FB+1)*CD;
   localparam int LB    = 2*FB+1;
   localparam int LAT_A = 260;
   localparam int LAT_B = 65;
`else
   localparam int LA    = 2*FB*CD;
   localparam int LB    = 2*FB;
   localparam int LAT_A = 256;
   localparam int LAT_B = 64;
`endif
   logic clk = 0, reset = 0, start_a = 0, start_b = 0;
   logic [FB-1:0] din_a = '0, din_b = '0, next_s = '0, sword = '0, cap = '0;
   logic sck_a, sdo_a, busy_a, done_a, sdi_a, sck_b, sdo_b, busy_b, done_b;
   logic [FB-1:0] dout_a, dout_b;
`ifdef SPI_MASTER_CS_EN
   logic cs_a, cs_b;
`endif
   logic [FB-1:0] lit_tx [4] = '{32'hA5A5_00FF, 32'hA5A5_00FF, 32'h0000_0001, 32'h8000_0000};
   logic [FB-1:0] lit_rx [4] = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0F0F_1234, 32'h8BAD_F00D};
   int npass = 0, ntot = 0, cyc = 0;
   logic ma_act = 0, ma_done = 0, ma_sdo = 0, mb_act = 0, mb_done = 0, prev_sck = 0;
   logic [FB-1:0] ma_d = '0, ma_s = '0, ma_dout = '0, mb_d = '0, mb_dout = '0;
   int ma_e0 = 0, mb_e0 = 0, t, u, k, nrise = 0, fno = 0, bno = 0, last_done = 0;
   assign sdi_a = sword[FB-1];
   spi_master_tx #(.CLK_DIV(CD), .FRAME_BITS(FB)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .din(din_a), .sdi(sdi_a),
      .sck(sck_a), .sdo(sdo_a), .dout(dout_a), .busy(busy_a), .done(done_a)
`ifdef SPI_MASTER_CS_EN
      , .cs_n(cs_a)
`endif
   );
   spi_master_tx #(.CLK_DIV(1), .FRAME_BITS(FB)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .din(din_b), .sdi(sdo_b),
      .sck(sck_b), .sdo(sdo_b), .dout(dout_b), .busy(busy_b), .done(done_b)
`ifdef SPI_MASTER_CS_EN
      , .cs_n(cs_b)
`endif
   );
   initial forever #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      ntot++;
      if (a === e) npass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, a, e, cyc);
   endtask
   // frame-level model: each frame is an acceptance time plus the words in flight
   initial forever begin
      @(posedge clk);
      cyc++;
      ma_done = 0;
      mb_done = 0;
      if (!reset) begin
         ma_act = 0; ma_dout = '0; ma_sdo = 0; mb_act = 0; mb_dout = '0;
      end else begin
         if (ma_act) begin
            if (cyc - ma_e0 == LA) begin ma_act = 0; ma_done = 1; ma_dout = ma_s; ma_sdo = ma_d[0]; end
         end else if (start_a) begin
            ma_act = 1; ma_e0 = cyc; ma_d = din_a; ma_s = sword;
         end
         if (mb_act) begin
            if (cyc - mb_e0 == LB) begin mb_act = 0; mb_done = 1; mb_dout = mb_d; end
         end else if (start_b) begin
            mb_act = 1; mb_e0 = cyc; mb_d = din_b;
         end
      end
   end
   initial forever begin
      @(negedge clk);
      t = cyc - ma_e0;
      u = cyc - mb_e0;
      k = t / (2*CD);
      if (k > FB-1) k = FB-1;
      chk("busy_a", busy_a, ma_act);
      chk("sck_a", sck_a, ma_act && t < 2*FB*CD && (t/CD) % 2 == 1);
      chk("sdo_a", sdo_a, ma_act ? ma_d[FB-1-k] : ma_sdo);
      chk("done_a", done_a, ma_done);
      chk("dout_a", dout_a, ma_dout);
      chk("busy_b", busy_b, mb_act);
      chk("sck_b", sck_b, mb_act && u < 2*FB && u % 2 == 1);
      chk("done_b", done_b, mb_done);
      chk("dout_b", dout_b, mb_dout);
`ifdef SPI_MASTER_CS_EN
      chk("cs_n_a", cs_a, !ma_act);
      chk("cs_n_b", cs_b, !mb_act);
`endif
      if (!prev_sck && sck_a) begin
         if (nrise == 0) chk("first_rise_a", t, 4);
         cap = {cap[FB-2:0], sdo_a};
         nrise++;
      end
      if (done_a) begin
         chk("rx_word_a", cap, ma_d);
         chk("rises_a", nrise, 32);
         chk("latency_a", cyc - ma_e0, LAT_A);
         if (fno < 4) begin
            chk("lit_tx", cap, lit_tx[fno]);
            chk("lit_rx", dout_a, lit_rx[fno]);
         end
         if (fno == 3) chk("b2b_gap", cyc - last_done, LAT_A + 1);
         last_done = cyc;
         fno++;
      end
      if (done_b) begin
         chk("latency_b", cyc - mb_e0, LAT_B);
         if (bno == 0) chk("lit_loop", dout_b, 32'hDEAD_BEEF);
         bno++;
      end
      if (!busy_a) begin
         nrise = 0;
         sword = next_s;
      end else if (prev_sck && !sck_a) sword = sword << 1;
      prev_sck = sck_a;
   end
   task automatic wait_done();
      int n = 0;
      while (!done_a && n < 2000) begin @(posedge clk); #1; n++; end
      chk("wait_done_a", done_a, 1);
   endtask
   task automatic frame_a(input logic [FB-1:0] d, input logic [FB-1:0] s, input int poke);
      next_s = s; din_a = d; start_a = 1;
      @(posedge clk); #1;
      start_a = 0; din_a = $urandom;
      if (poke > 0) begin
         repeat (poke - 1) @(posedge clk);
         #1;
         start_a = 1; din_a = '0;
         @(posedge clk); #1;
         start_a = 0;
      end
      wait_done();
      @(posedge clk); #1;
   endtask
   task automatic frame_b(input logic [FB-1:0] d);
      int n = 0;
      din_b = d; start_b = 1;
      @(posedge clk); #1;
      start_b = 0; din_b = $urandom;
      while (!done_b && n < 500) begin @(posedge clk); #1; n++; end
      chk("wait_done_b", done_b, 1);
      @(posedge clk); #1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy_a, 0);
      chk("rst_sck", sck_a, 0);
      chk("rst_dout", dout_a, 0);
      reset = 1;
      frame_a(32'hA5A5_00FF, 32'h1234_5678, 0);
      frame_a(32'hA5A5_00FF, 32'hCAFE_F00D, 50);
      frame_b(32'hDEAD_BEEF);
      next_s = lit_rx[2]; din_a = 32'h0000_0001; start_a = 1;
      @(posedge clk); #1;
      din_a = 32'h8000_0000; next_s = lit_rx[3];
      wait_done();
      @(posedge clk); #1;
      start_a = 0;
      wait_done();
      @(posedge clk); #1;
      next_s = $urandom; din_a = $urandom; start_a = 1;
      @(posedge clk); #1;
      start_a = 0;
      repeat (99) @(posedge clk);
      #1 reset = 0;
      @(posedge clk);
      #1 reset = 1;
      chk("abort_busy", busy_a, 0);
      chk("abort_sck", sck_a, 0);
      chk("abort_sdo", sdo_a, 0);
      chk("abort_dout", dout_a, 0);
      chk("abort_done", done_a, 0);
      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         frame_a($urandom, $urandom, $urandom_range(0, 1) ? $urandom_range(2, LA - 2) : 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      for (int i = 0; i < 6; i++) frame_b($urandom);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
